// File: rtl/alu_seq.sv
// Instruction sequencer for the 8-bit ALU: owns R0-R3, runs each instruction
// through READ/EXEC/WRITE and drives an external combinational ALU.
module alu_seq #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [5:0] instr,
   output logic       instr_ready,
   input  logic       ld_en,
   input  logic [1:0] ld_addr,
   input  logic [7:0] ld_data,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [1:0] alu_opcode,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   output logic       done,
   output logic       div_zero,
   input  logic       err_clr
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   localparam logic [1:0] OP_DIV = 2'b11;

   state_t     state, next_state;
   logic [1:0] op_q, ra_q, rb_q;
   logic [7:0] res_q;
   logic       zflag;
   logic       wb_en;
   logic [7:0] regs [4];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      next_state  = state;
      instr_ready = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) next_state = READ;
         end
         READ:  next_state = EXEC;
         EXEC:  next_state = WRITE;
         WRITE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign wb_en = (state == WRITE) && !zflag;

   // NOTE: the register file has a real reset because RESET_VAL is architecturally visible.
   // Writeback outranks a host load to the same register in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) regs[i] <= RESET_VAL;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wb_en && ra_q == 2'(i))          regs[i] <= res_q;
            else if (ld_en && ld_addr == 2'(i))  regs[i] <= ld_data;
         end
      end
   end

   assign rd_data = regs[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= 2'b00;
         ra_q       <= 2'b00;
         rb_q       <= 2'b00;
         alu_opcode <= 2'b00;
         alu_a      <= RESET_VAL;
         alu_b      <= RESET_VAL;
         res_q      <= RESET_VAL;
         zflag      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q <= instr[5:4];
                  ra_q <= instr[3:2];
                  rb_q <= instr[1:0];
               end
            end
            READ: begin
               alu_a      <= regs[ra_q];
               alu_b      <= regs[rb_q];
               alu_opcode <= op_q;
            end
            EXEC: begin
               res_q <= alu_result;
               zflag <= (alu_opcode == OP_DIV) && (alu_b == 8'h00);
            end
            default: ;
         endcase
      end
   end

   // A new divide-by-zero in WRITE beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       div_zero <= 1'b0;
      else if (state == WRITE && zflag) div_zero <= 1'b1;
      else if (err_clr)                 div_zero <= 1'b0;
   end

endmodule
